// File: rtl/sobel_pkg.sv
// Widths shared by the Sobel radicand generator and the downstream square-root stage.
// RAD_W is the contract with the square-root stage; change both sides together.
package sobel_pkg;
  localparam int PIX_W     = 8;
  localparam int GRAD_W    = 11;
  localparam int SUM_W     = 22;
  localparam int RAD_W     = 16;
  localparam int RAD_SHIFT = 5;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [RAD_W-1:0] rad_t;
endpackage

// File: rtl/sobel_radicand_gen_if.sv
// Pixel-in / radicand-out valid-ready handshakes of the Sobel radicand generator.
// master is the side feeding pixels and consuming radicands; slave is the generator.
interface sobel_radicand_gen_if;
  import sobel_pkg::*;

  logic pix_valid;
  logic pix_ready;
  pix_t pix_in;
  logic sof;
  logic rad_valid;
  logic rad_ready;
  rad_t rad_out;

  modport master (
    output pix_valid, pix_in, sof, rad_ready,
    input  pix_ready, rad_valid, rad_out
  );

  modport slave (
    input  pix_valid, pix_in, sof, rad_ready,
    output pix_ready, rad_valid, rad_out
  );
endinterface

// File: rtl/sobel_line_buffer.sv
// Two IMG_W-deep line stores holding rows r-1 and r-2, sharing one column index.
// Reads are combinational so the old contents are seen before the write at the edge.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int IMG_W = 64
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(IMG_W)-1:0] col_i,
  input  pix_t                     pix_i,
  output pix_t                     row1_o,
  output pix_t                     row2_o
);
  pix_t row1_mem [IMG_W];
  pix_t row2_mem [IMG_W];

  assign row1_o = row1_mem[col_i];
  assign row2_o = row2_mem[col_i];

  // Storage is deliberately unreset; row/col gating keeps stale data out of results.
  always_ff @(posedge clk) begin
    if (we_i) begin
      row1_mem[col_i] <= pix_i;
      row2_mem[col_i] <= row1_mem[col_i];
    end
  end
endmodule

// File: rtl/sobel_radicand_gen.sv
// 3x3 Sobel gradient magnitude radicand, (Gx^2+Gy^2)>>5, in a three-stage pipeline.
// Every stage moves only when the output slot is free or being consumed.
module sobel_radicand_gen
  import sobel_pkg::*;
#(
  parameter int IMG_W = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  sobel_radicand_gen_if.slave bus
);
  localparam int              COL_W     = $clog2(IMG_W);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(2);
  localparam logic [1:0]       ROW_SAT   = 2'd2;

  function automatic logic signed [GRAD_W-1:0] zx(input pix_t p);
    return $signed(GRAD_W'(p));
  endfunction

  // (b0 + 2*b1 + b2) - (a0 + 2*a1 + a2); fits 11 bits signed for 8-bit pixels.
  function automatic logic signed [GRAD_W-1:0] grad(input pix_t a0, a1, a2, b0, b1, b2);
    return (zx(b0) + (zx(b1) <<< 1) + zx(b2)) - (zx(a0) + (zx(a1) <<< 1) + zx(a2));
  endfunction

  function automatic logic [SUM_W-1:0] mag_sq(input logic signed [GRAD_W-1:0] gx, gy);
    logic signed [SUM_W-1:0] x, y;
    x = SUM_W'(gx);
    y = SUM_W'(gy);
    return x * x + y * y;
  endfunction

  // Plain truncation: the largest sum (2*1020^2) still lands within 16 bits.
  function automatic rad_t rad_trunc(input logic [SUM_W-1:0] s);
    return RAD_W'(s >> RAD_SHIFT);
  endfunction

  logic                     adv, accept;
  logic [COL_W-1:0]         col_q, col_d, col_eff;
  logic [1:0]               row_q, row_d, row_eff;
  pix_t                     lb_r1, lb_r2;
  pix_t                     win_p0_q [3][3];
  logic                     vld_p0_q, vld_p1_q, vld_p2_q;
  logic signed [GRAD_W-1:0] gx_p1_q, gy_p1_q;
  rad_t                     rad_p2_q;

  assign adv           = !vld_p2_q || bus.rad_ready;
  assign accept        = bus.pix_valid && adv;
  assign bus.pix_ready = adv;
  assign bus.rad_valid = vld_p2_q;
  assign bus.rad_out   = rad_p2_q;

  // sof forces the accepted pixel to (0,0) before any gating or indexing uses it.
  always_comb begin
    col_eff = bus.sof ? '0 : col_q;
    row_eff = bus.sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (accept) begin
      col_d = col_eff + COL_W'(1);
      row_d = row_eff;
      if (col_eff == COL_LAST) begin
        col_d = '0;
        if (row_eff != ROW_SAT) row_d = row_eff + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  sobel_line_buffer #(.IMG_W(IMG_W)) u_line_buffer (
    .clk    (clk),
    .we_i   (accept),
    .col_i  (col_eff),
    .pix_i  (bus.pix_in),
    .row1_o (lb_r1),
    .row2_o (lb_r2)
  );

  // S1: window capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) win_p0_q[i][j] <= '0;
      vld_p0_q <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < 3; i++) begin
          win_p0_q[i][0] <= win_p0_q[i][1];
          win_p0_q[i][1] <= win_p0_q[i][2];
        end
        win_p0_q[0][2] <= lb_r2;
        win_p0_q[1][2] <= lb_r1;
        win_p0_q[2][2] <= bus.pix_in;
      end
      if (adv) vld_p0_q <= accept && (row_eff == ROW_SAT) && (col_eff >= COL_FIRST);
    end
  end

  // S2: gradients
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1_q <= 1'b0;
    else if (adv) vld_p1_q <= vld_p0_q;
  end

  always_ff @(posedge clk) begin
    if (adv && vld_p0_q) begin
      gx_p1_q <= grad(win_p0_q[0][0], win_p0_q[1][0], win_p0_q[2][0],
                      win_p0_q[0][2], win_p0_q[1][2], win_p0_q[2][2]);
      gy_p1_q <= grad(win_p0_q[0][0], win_p0_q[0][1], win_p0_q[0][2],
                      win_p0_q[2][0], win_p0_q[2][1], win_p0_q[2][2]);
    end
  end

  // S3: squares, sum, shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2_q <= 1'b0;
      rad_p2_q <= '0;
    end else if (adv) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) rad_p2_q <= rad_trunc(mag_sq(gx_p1_q, gy_p1_q));
    end
  end
endmodule
